rtp_hit_collector: RTL and testbench

- Downstream consumer of the RTP core. Captures each per-ray result `{ray_id, hitT, hitIndex}` on the RTP finish pulse and buffers it in a small FIFO.
- Drains the FIFO through a ready/valid write port into the hit-result memory.
- Counts completed rays against a programmed total and raises a batch-done flag once every ray of the batch has been written back.

---
 rtl/rtp_hit_collector.sv | 157 +++++++++++++++
 tb/tb_rtp_hit_collector.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtp_hit_collector.sv
// Captures per-ray RTP results into a FIFO and drains them to the hit-result memory.
// Define HIT_STATS_EN to add the io_hit_count / io_miss_count write-back counters.
module rtp_hit_collector #(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
   parameter logic [31:0] MISS_INDEX = 32'hFFFF_FFFF
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        io_start,
   input  logic [31:0] io_num_rays,
   input  logic        io_rtp_finish,
   input  logic [31:0] io_ray_id_triangle,
   input  logic [31:0] io_hitT,
   input  logic [31:0] io_hitIndex,
   output logic        io_res_wrValid,
   input  logic        io_res_wrReady,
   output logic [31:0] io_res_wrAddr,
   output logic [63:0] io_res_wrData,
   output logic        io_busy,
   output logic        io_batch_done,
   output logic        io_overflow,
   output logic [31:0] io_rays_done
`ifdef HIT_STATS_EN
   ,
   output logic [31:0] io_hit_count,
   output logic [31:0] io_miss_count
`endif
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam logic [31:0] POS_INF = 32'h7F80_0000;

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN, S_DONE} state_e;

   state_e      state_q, state_d;
   logic [31:0] num_rays_q, num_rays_d;
   logic [31:0] accepted_q, accepted_d;
   logic [31:0] rays_done_q, rays_done_d;
   logic        overflow_q, overflow_d;
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;

   // Entry layout: {wrAddr[31:0], hitIndex[31:0], normalised hitT[31:0]}
   logic [95:0] mem_q [FIFO_DEPTH];
   logic [95:0] entry_in;
   logic [95:0] head;

   logic fifo_empty, fifo_full;
   logic start_ok, take, push, pop, drop;

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head       = mem_q[rd_ptr_q[AW-1:0]];

   assign start_ok = io_start && ((state_q == S_IDLE) || (state_q == S_DONE));
   assign take     = io_rtp_finish && (state_q == S_COLLECT) && (accepted_q != num_rays_q);
   assign pop      = !fifo_empty && io_res_wrReady;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign push     = take && (!fifo_full || pop);
   assign drop     = take && fifo_full && !pop;

   assign entry_in = {ADDR_BASE + io_ray_id_triangle,
                      io_hitIndex,
                      (io_hitIndex == MISS_INDEX) ? POS_INF : io_hitT};

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (io_start) state_d = (io_num_rays == 32'd0) ? S_DONE : S_COLLECT;
         end
         S_COLLECT: begin
            if (accepted_d == num_rays_q) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (fifo_empty) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      io_busy        = (state_q == S_COLLECT) || (state_q == S_DRAIN);
      io_batch_done  = (state_q == S_DONE);
      io_overflow    = overflow_q;
      io_rays_done   = rays_done_q;
      io_res_wrValid = !fifo_empty;
      io_res_wrAddr  = fifo_empty ? 32'd0 : head[95:64];
      io_res_wrData  = fifo_empty ? 64'd0 : head[63:0];
   end

   always_comb begin
      num_rays_d  = start_ok ? io_num_rays : num_rays_q;
      accepted_d  = start_ok ? 32'd0 : accepted_q + {31'd0, take};
      rays_done_d = start_ok ? 32'd0 : rays_done_q + {31'd0, pop};
      overflow_d  = start_ok ? 1'b0  : (overflow_q || drop);
      wr_ptr_d    = wr_ptr_q + {{AW{1'b0}}, push};
      rd_ptr_d    = rd_ptr_q + {{AW{1'b0}}, pop};
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         num_rays_q  <= 32'd0;
         accepted_q  <= 32'd0;
         rays_done_q <= 32'd0;
         overflow_q  <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
      end else begin
         num_rays_q  <= num_rays_d;
         accepted_q  <= accepted_d;
         rays_done_q <= rays_done_d;
         overflow_q  <= overflow_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
      end
   end

   // Payload storage carries no reset; the pointers alone define validity.
   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= entry_in;
   end

`ifdef HIT_STATS_EN
   logic [31:0] hit_cnt_q, hit_cnt_d;
   logic [31:0] miss_cnt_q, miss_cnt_d;
   logic        head_miss;

   assign head_miss = (head[63:32] == MISS_INDEX);

   always_comb begin
      hit_cnt_d  = start_ok ? 32'd0 : hit_cnt_q  + {31'd0, pop && !head_miss};
      miss_cnt_d = start_ok ? 32'd0 : miss_cnt_q + {31'd0, pop &&  head_miss};
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hit_cnt_q  <= 32'd0;
         miss_cnt_q <= 32'd0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign io_hit_count  = hit_cnt_q;
   assign io_miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_rtp_hit_collector.sv
// Randomised bench for rtp_hit_collector against a queue-based reference model.
// Covers basic, miss, backpressure, overflow, zero-batch and mid-drain reset cases.
module tb_rtp_hit_collector;

   localparam int          DEPTH = 8;
   localparam logic [31:0] MISS  = 32'hFFFF_FFFF;
   localparam logic [31:0] BASE  = 32'h0000_0000;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        io_start = 1'b0;
   logic [31:0] io_num_rays = '0;
   logic        io_rtp_finish = 1'b0;
   logic [31:0] io_ray_id_triangle = '0;
   logic [31:0] io_hitT = '0;
   logic [31:0] io_hitIndex = '0;
   logic        io_res_wrValid;
   logic        io_res_wrReady = 1'b0;
   logic [31:0] io_res_wrAddr;
   logic [63:0] io_res_wrData;
   logic        io_busy;
   logic        io_batch_done;
   logic        io_overflow;
   logic [31:0] io_rays_done;
`ifdef HIT_STATS_EN
   logic [31:0] io_hit_count;
   logic [31:0] io_miss_count;
`endif

   always #5 clock = ~clock;

   rtp_hit_collector #(
      .FIFO_DEPTH(DEPTH),
      .ADDR_BASE (BASE),
      .MISS_INDEX(MISS)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .io_start          (io_start),
      .io_num_rays       (io_num_rays),
      .io_rtp_finish     (io_rtp_finish),
      .io_ray_id_triangle(io_ray_id_triangle),
      .io_hitT           (io_hitT),
      .io_hitIndex       (io_hitIndex),
      .io_res_wrValid    (io_res_wrValid),
      .io_res_wrReady    (io_res_wrReady),
      .io_res_wrAddr     (io_res_wrAddr),
      .io_res_wrData     (io_res_wrData),
      .io_busy           (io_busy),
      .io_batch_done     (io_batch_done),
      .io_overflow       (io_overflow),
      .io_rays_done      (io_rays_done)
`ifdef HIT_STATS_EN
      ,
      .io_hit_count      (io_hit_count),
      .io_miss_count     (io_miss_count)
`endif
   );

   int n_checks = 0;
   int n_err    = 0;

   // Reference model state
   logic [31:0] mq_addr[$];
   logic [63:0] mq_data[$];
   int          m_num, m_acc, m_done, m_drops, m_hits, m_miss;
   bit          m_active, m_ovf;

   logic [31:0] s_id [64];
   logic [31:0] s_t  [64];
   logic [31:0] s_idx[64];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] exp_data(input logic [31:0] t, input logic [31:0] idx);
      return {idx, (idx == MISS) ? 32'h7F80_0000 : t};
   endfunction

   task automatic model_reset();
      mq_addr.delete();
      mq_data.delete();
      m_num = 0; m_acc = 0; m_done = 0; m_drops = 0; m_hits = 0; m_miss = 0;
      m_active = 0; m_ovf = 0;
   endtask

   // Compare outputs mid-cycle, then advance the model across the next rising edge.
   task automatic step();
      bit          pop, push;
      logic [31:0] a;
      logic [63:0] d;
      @(negedge clock);
      chk("wrValid", io_res_wrValid, mq_addr.size() > 0);
      if (mq_addr.size() > 0) begin
         chk("wrAddr", io_res_wrAddr, mq_addr[0]);
         chk("wrData", io_res_wrData, mq_data[0]);
      end
      chk("rays_done", io_rays_done, m_done);
      chk("overflow", io_overflow, m_ovf);
      if (m_active) begin
         chk("busy", io_busy, 1);
         chk("batch_done_early", io_batch_done, 0);
      end
`ifdef HIT_STATS_EN
      chk("hit_count", io_hit_count, m_hits);
      chk("miss_count", io_miss_count, m_miss);
`endif
      pop  = (mq_addr.size() > 0) && io_res_wrReady;
      push = 0;
      a    = '0;
      d    = '0;
      if (io_rtp_finish && m_active && m_acc < m_num) begin
         m_acc++;
         if (mq_addr.size() == DEPTH && !pop) begin
            m_ovf = 1;
            m_drops++;
         end else begin
            push = 1;
            a    = BASE + io_ray_id_triangle;
            d    = exp_data(io_hitT, io_hitIndex);
         end
      end
      if (pop) begin
         if (mq_data[0][63:32] == MISS) m_miss++;
         else                           m_hits++;
         void'(mq_addr.pop_front());
         void'(mq_data.pop_front());
         m_done++;
      end
      if (push) begin
         mq_addr.push_back(a);
         mq_data.push_back(d);
      end
      if (io_start && !m_active) begin
         m_num = int'(io_num_rays);
         m_acc = 0; m_done = 0; m_drops = 0; m_hits = 0; m_miss = 0; m_ovf = 0;
         m_active = (io_num_rays != 0);
      end else if (m_active && m_acc == m_num && mq_addr.size() == 0) begin
         m_active = 0;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic fill_rand(input int n);
      for (int i = 0; i < n; i++) begin
         s_id[i]  = $urandom;
         s_t[i]   = $urandom;
         s_idx[i] = ($urandom_range(3) == 0) ? MISS : 32'($urandom_range(1000));
      end
   endtask

   task automatic run_batch(input int num, input int npl, input int ppct,
                            input int rpct, input int hold);
      int cyc;
      int sent;
      cyc  = 0;
      sent = 0;
      io_start       = 1'b1;
      io_num_rays    = 32'(num);
      io_rtp_finish  = 1'b0;
      io_res_wrReady = 1'b0;
      step();
      io_start = 1'b0;
      while (cyc < 300 && !(sent >= npl && !m_active && io_batch_done)) begin
         io_rtp_finish = (sent < npl) && ($urandom_range(99) < 32'(ppct));
         if (io_rtp_finish) begin
            io_ray_id_triangle = s_id[sent];
            io_hitT            = s_t[sent];
            io_hitIndex        = s_idx[sent];
            sent++;
         end
         io_res_wrReady = (cyc >= hold) && ($urandom_range(99) < 32'(rpct));
         step();
         cyc++;
      end
      io_rtp_finish = 1'b0;
      chk("batch_timeout", cyc < 300, 1);
      if (num == 0) chk("zero_batch_latency", cyc <= 2, 1);
      chk("batch_done", io_batch_done, 1);
      chk("busy_after_batch", io_busy, 0);
      chk("rays_done_total", io_rays_done, 32'(num - m_drops));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      repeat (3) @(posedge clock);
      #1;
      chk("rst_wrValid", io_res_wrValid, 0);
      chk("rst_wrAddr", io_res_wrAddr, 0);
      chk("rst_wrData", io_res_wrData, 0);
      chk("rst_busy", io_busy, 0);
      chk("rst_batch_done", io_batch_done, 0);
      chk("rst_overflow", io_overflow, 0);
      chk("rst_rays_done", io_rays_done, 0);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;

      // Basic three-ray batch
      s_id[0] = 5; s_id[1] = 6; s_id[2] = 7;
      for (int i = 0; i < 3; i++) begin
         s_t[i]   = 32'h3F80_0000;
         s_idx[i] = 32'(i + 1);
      end
      run_batch(3, 3, 100, 100, 0);

      // Miss normalisation
      s_id[0] = 9; s_t[0] = 32'h4120_0000; s_idx[0] = MISS;
      run_batch(1, 1, 100, 100, 0);
`ifdef HIT_STATS_EN
      chk("miss_count_final", io_miss_count, 1);
      chk("hit_count_final", io_hit_count, 0);
`endif

      // Backpressure: four results held for ten cycles
      fill_rand(4);
      run_batch(4, 4, 100, 100, 10);

      // Overflow: ten results into an eight-entry FIFO
      fill_rand(10);
      run_batch(10, 10, 100, 100, 15);
      chk("overflow_set", io_overflow, 1);
      chk("overflow_rays_done", io_rays_done, 8);

      // Pulses beyond num_rays are ignored even when the FIFO is full
      fill_rand(11);
      run_batch(8, 11, 100, 100, 14);
      chk("extra_no_overflow", io_overflow, 0);

      // Zero-length batch
      run_batch(0, 0, 100, 100, 0);

      // Finish pulses while DONE are ignored
      io_rtp_finish = 1'b1;
      io_res_wrReady = 1'b1;
      for (int i = 0; i < 3; i++) begin
         io_ray_id_triangle = $urandom;
         io_hitIndex        = 32'(i);
         step();
      end
      io_rtp_finish = 1'b0;
      chk("done_ignores_finish", io_batch_done, 1);

      // Randomised batches
      for (int k = 0; k < 8; k++) begin
         int n;
         n = int'($urandom_range(20, 1));
         fill_rand(n + 2);
         run_batch(n, n + int'($urandom_range(2)), 50, 40, int'($urandom_range(8)));
      end

      // Reset while results are queued
      fill_rand(3);
      io_start = 1'b1; io_num_rays = 3; io_res_wrReady = 1'b0;
      step();
      io_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         io_rtp_finish = 1'b1;
         io_ray_id_triangle = s_id[i]; io_hitT = s_t[i]; io_hitIndex = s_idx[i];
         step();
      end
      io_rtp_finish = 1'b0;
      step();
      step();
      reset = 1'b0;
      #1;
      chk("mid_rst_wrValid", io_res_wrValid, 0);
      chk("mid_rst_wrAddr", io_res_wrAddr, 0);
      chk("mid_rst_wrData", io_res_wrData, 0);
      chk("mid_rst_busy", io_busy, 0);
      chk("mid_rst_batch_done", io_batch_done, 0);
      chk("mid_rst_overflow", io_overflow, 0);
      chk("mid_rst_rays_done", io_rays_done, 0);
      model_reset();
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      fill_rand(1);
      run_batch(1, 1, 100, 100, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
